gb_stream_source: RTL and testbench
===================================

# gb_stream_source

Raster-order 8-bit pixel stream transmitter that drives the `arg_1` input stream (`TDATA`/`TVALID`/`TREADY`) of the Gaussian-blur accelerator and its ILA models. It generates one full frame per `start` pulse from a selectable deterministic pattern. A programmable idle gap between beats exercises the `arg_1_TREADY` handshake and the line-buffer stall paths. It sits in the simulation and equivalence benches upstream of the DUT, which is the receiver of this stream.

## Interface
Parameters:
- `IMG_W`, default 488: pixels per line; must fit in 9 bits.
- `IMG_H`, default 648: lines per frame; must fit in 10 bits.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low; `rst=0` resets immediately.
- `start`  in  1: begin a frame; sampled only in IDLE.
- `pattern_sel`  in  2: pattern select, latched at the accepted `start`.
- `seed`  in  8: pattern seed, latched at the accepted `start`.
- `gap`  in  4: idle cycles inserted after each beat, latched at the accepted `start`.
- `arg_1_TDATA`  out  8: pixel data.
- `arg_1_TVALID`  out  1: pixel valid.
- `arg_1_TREADY`  in  1: DUT ready.
- `busy`  out  1: high from the accepted `start` through the last beat.
- `done`  out  1: one-cycle pulse after the last beat.
- `pix_x`  out  9: x coordinate of the current/pending pixel.
- `pix_y`  out  10: y coordinate of the current/pending pixel.
- `pix_cnt`  out  19: beats transferred this frame.

## Operation
- States:
  - IDLE: `start=1` → SEND; latches pattern, seed and gap; clears x, y and count.
  - SEND: `TVALID=1`. On a beat (`TVALID & TREADY`):
    - last pixel → DONE;
    - otherwise, if `gap=0` → stay in SEND with the next pixel;
    - otherwise → GAP.
  - GAP: `TVALID=0`; a down-counter loaded with `gap` decrements each cycle; → SEND when it reaches 1.
  - DONE: `done=1` for one cycle → IDLE.
- Pixel pattern, computed from the latched values and the current (x, y):
  - 0 ramp: `(x + y + seed)[7:0]`, modulo 256.
  - 1 LFSR: 8-bit Fibonacci LFSR with taps 8, 6, 5, 4. Loaded with `seed` at start; `seed=0` loads 0x01. Advances once per beat. The first pixel is the seed value.
  - 2 constant: `seed` for every pixel.
  - 3 xor: `x[7:0] ^ y[7:0] ^ seed`.
- Raster order:
  - x increments per beat.
  - At `x = IMG_W-1`, x wraps to 0 and y increments.
  - Last pixel is `x = IMG_W-1`, `y = IMG_H-1`; at that point `pix_cnt` becomes `IMG_W*IMG_H` (316224 at defaults).
- Handshake rules (AXI-stream source):
  - Once `TVALID` rises, `TVALID` and `TDATA` hold stable until a beat occurs.
  - `TVALID` never depends combinationally on `TREADY`.
  - `TREADY` asserted while `TVALID=0` has no effect.
- `start` while `busy` is ignored. Inputs latched at start are frozen for the whole frame; changes mid-frame have no effect.
- Reset values: `TVALID=0`, `TDATA=0`, `busy=0`, `done=0`, `pix_x=0`, `pix_y=0`, `pix_cnt=0`, state IDLE.
- Reset asserted mid-frame:
  - all outputs take their reset values immediately (asynchronously);
  - the frame is abandoned; no `done` pulse.

## Timing
- `start` high at edge N → `TVALID=1` with pixel (0,0) and `busy=1` after edge N.
- With `gap=0` and `TREADY` held high: one beat per cycle, a full frame in `IMG_W*IMG_H` cycles.
- With `gap=G`: a beat is followed by G cycles of `TVALID=0`. Beat spacing is G+1 cycles under constant ready.
- `done` is high during the cycle after the last beat's edge; `busy` falls in that same cycle.
- Earliest next `start` acceptance is the edge that ends the DONE cycle plus one, i.e. in IDLE.
- Output latency from the next-pixel decision to `TDATA` is 0: `TDATA` is a register updated on the beat edge.

## Structure
- Package `gb_stream_pkg` holds:
  - `GB_IMG_W=488`, `GB_IMG_H=648`, `GB_PIX_CNT_W=19`;
  - `gb_pattern_e` {RAMP, LFSR, CONST, XOR};
  - state enum `gb_src_state_e` {IDLE, SEND, GAP, DONE};
  - `GB_LFSR_TAPS=8'hB8`.
- One sub-module, `gb_lfsr8`: load/advance enable, 8-bit state, zero-seed substitution to 0x01.

## Test plan
- Ramp, `seed=0`, `gap=0`, `TREADY=1`, reduced `IMG_W=4`, `IMG_H=3` → data 0,1,2,3,1,2,3,4,2,3,4,5 on consecutive cycles; `done` one cycle after the 12th beat; `pix_cnt=12`.
- Backpressure: `TREADY` low for 5 cycles mid-line → `TVALID` and `TDATA` unchanged across all 5 cycles; no pixel skipped or duplicated.
- `gap=3` with constant pattern `seed=0xA5` → `TVALID` high 1 of every 4 cycles; every beat carries 0xA5.
- LFSR with `seed=0` → first pixel 0x01; sequence matches the reference model for 255 beats, then repeats.
- `start` pulsed mid-frame → ignored; counts continue. Reset pulled low at beat 7 → `TVALID=0` immediately; no `done`; after release, a new `start` begins again at (0,0).
- Full default frame at `gap=0` → exactly 316224 beats; `pix_x` and `pix_y` wrap correctly at 487 and 647.

Source files
------------

// File: rtl/gb_stream_pkg.sv
// Shared types, constants and pattern helpers for the gb_stream_source pixel transmitter.
package gb_stream_pkg;

  localparam int unsigned GB_IMG_W     = 488;
  localparam int unsigned GB_IMG_H     = 648;
  localparam int unsigned GB_PIX_CNT_W = 19;
  localparam int unsigned GB_X_W       = 9;
  localparam int unsigned GB_Y_W       = 10;
  localparam logic [7:0]  GB_LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {RAMP, LFSR, CONST, XOR} gb_pattern_e;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} gb_src_state_e;

  // A zero seed would lock the LFSR, so it is replaced by 0x01.
  function automatic logic [7:0] gb_lfsr_seed(input logic [7:0] s);
    return (s == 8'd0) ? 8'h01 : s;
  endfunction

  function automatic logic [7:0] gb_lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & GB_LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] gb_pixel(input gb_pattern_e pat,
                                          input logic [7:0]  seed,
                                          input logic [GB_X_W-1:0] x,
                                          input logic [GB_Y_W-1:0] y,
                                          input logic [7:0]  lfsr);
    logic [7:0] w_x8;
    logic [7:0] w_y8;
    w_x8 = 8'(x);
    w_y8 = 8'(y);
    case (pat)
      RAMP:    return w_x8 + w_y8 + seed;
      LFSR:    return lfsr;
      CONST:   return seed;
      default: return w_x8 ^ w_y8 ^ seed;
    endcase
  endfunction

endpackage

// File: rtl/gb_stream_source_lfsr.sv
// 8-bit Fibonacci LFSR with synchronous load (zero seed substituted) and advance enable.
module gb_lfsr8
  import gb_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_seed,
  input  logic       i_adv,
  output logic [7:0] o_state,
  output logic [7:0] o_next_c
);

  logic [7:0] r_state;

  assign o_state  = r_state;
  assign o_next_c = gb_lfsr_step(r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= 8'h01;
    end else if (i_load) begin
      r_state <= gb_lfsr_seed(i_seed);
    end else if (i_adv) begin
      r_state <= o_next_c;
    end
  end

endmodule

// File: rtl/gb_stream_source.sv
// Raster-order 8-bit AXI-stream pixel source: one frame per start, selectable pattern,
// programmable idle gap after each beat.
module gb_stream_source
  import gb_stream_pkg::*;
#(
  parameter int unsigned IMG_W = GB_IMG_W,
  parameter int unsigned IMG_H = GB_IMG_H
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              pattern_sel,
  input  logic [7:0]              seed,
  input  logic [3:0]              gap,
  output logic [7:0]              arg_1_TDATA,
  output logic                    arg_1_TVALID,
  input  logic                    arg_1_TREADY,
  output logic                    busy,
  output logic                    done,
  output logic [GB_X_W-1:0]       pix_x,
  output logic [GB_Y_W-1:0]       pix_y,
  output logic [GB_PIX_CNT_W-1:0] pix_cnt
);

  localparam logic [GB_X_W-1:0] LAST_X = GB_X_W'(IMG_W - 1);
  localparam logic [GB_Y_W-1:0] LAST_Y = GB_Y_W'(IMG_H - 1);

  gb_src_state_e           r_state;
  gb_pattern_e             r_pat;
  logic [7:0]              r_seed;
  logic [3:0]              r_gap;
  logic [3:0]              r_gap_cnt;
  logic [GB_X_W-1:0]       r_x;
  logic [GB_Y_W-1:0]       r_y;
  logic [GB_PIX_CNT_W-1:0] r_cnt;
  logic [7:0]              r_tdata;
  logic                    r_tvalid;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_start;
  logic                    w_beat;
  logic                    w_last;
  logic                    w_eol;
  logic [GB_X_W-1:0]       w_x_nxt;
  logic [GB_Y_W-1:0]       w_y_nxt;
  logic [7:0]              w_lfsr;
  logic [7:0]              w_lfsr_nxt;
  logic [7:0]              w_first_pix;
  logic [7:0]              w_next_pix;

  assign w_start = (r_state == IDLE) && start;
  assign w_beat  = r_tvalid && arg_1_TREADY;
  assign w_eol   = (r_x == LAST_X);
  assign w_last  = w_eol && (r_y == LAST_Y);
  assign w_x_nxt = w_eol ? '0 : r_x + GB_X_W'(1);
  assign w_y_nxt = w_eol ? r_y + GB_Y_W'(1) : r_y;

  // Pixel (0,0) comes straight from the inputs being latched on the start edge.
  assign w_first_pix = gb_pixel(gb_pattern_e'(pattern_sel), seed, '0, '0, gb_lfsr_seed(seed));
  assign w_next_pix  = gb_pixel(r_pat, r_seed, w_x_nxt, w_y_nxt, w_lfsr_nxt);

  gb_lfsr8 u_lfsr (
    .clk      (clk),
    .rst_n    (rst),
    .i_load   (w_start),
    .i_seed   (seed),
    .i_adv    (w_beat),
    .o_state  (w_lfsr),
    .o_next_c (w_lfsr_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pat     <= RAMP;
      r_seed    <= 8'd0;
      r_gap     <= 4'd0;
      r_gap_cnt <= 4'd0;
      r_x       <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_tdata   <= 8'd0;
      r_tvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= SEND;
            r_pat    <= gb_pattern_e'(pattern_sel);
            r_seed   <= seed;
            r_gap    <= gap;
            r_x      <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_tdata  <= w_first_pix;
            r_tvalid <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        SEND: begin
          if (w_beat) begin
            r_cnt <= r_cnt + GB_PIX_CNT_W'(1);
            if (w_last) begin
              r_state  <= DONE;
              r_tvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_x     <= w_x_nxt;
              r_y     <= w_y_nxt;
              r_tdata <= w_next_pix;
              if (r_gap != 4'd0) begin
                r_state   <= GAP;
                r_tvalid  <= 1'b0;
                r_gap_cnt <= r_gap;
              end
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == 4'd1) begin
            r_state  <= SEND;
            r_tvalid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign arg_1_TDATA  = r_tdata;
  assign arg_1_TVALID = r_tvalid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pix_x        = r_x;
  assign pix_y        = r_y;
  assign pix_cnt      = r_cnt;

endmodule

// File: tb/tb_gb_stream_source.sv
// Self-checking bench for gb_stream_source: a 4x3 and a 20x15 instance share stimulus,
// outputs are checked against a raster/pattern reference model.
module tb_gb_stream_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  pattern_sel;
  logic [7:0]  seed;
  logic [3:0]  gap;
  logic        tready;

  logic [7:0]  s_tdata, l_tdata, m_tdata;
  logic        s_tvalid, l_tvalid, m_tvalid;
  logic        s_busy, l_busy, m_busy;
  logic        s_done, l_done, m_done;
  logic [8:0]  s_x, l_x, m_x;
  logic [9:0]  s_y, l_y, m_y;
  logic [18:0] s_cnt, l_cnt, m_cnt;

  bit          sel_l;
  int          checks;
  int          errors;
  logic [7:0]  captured [0:511];

  always #5 clk = ~clk;

  gb_stream_source #(.IMG_W(4), .IMG_H(3)) dut_s (
    .clk(clk), .rst(rst), .start(start), .pattern_sel(pattern_sel), .seed(seed), .gap(gap),
    .arg_1_TDATA(s_tdata), .arg_1_TVALID(s_tvalid), .arg_1_TREADY(tready),
    .busy(s_busy), .done(s_done), .pix_x(s_x), .pix_y(s_y), .pix_cnt(s_cnt)
  );

  gb_stream_source #(.IMG_W(20), .IMG_H(15)) dut_l (
    .clk(clk), .rst(rst), .start(start), .pattern_sel(pattern_sel), .seed(seed), .gap(gap),
    .arg_1_TDATA(l_tdata), .arg_1_TVALID(l_tvalid), .arg_1_TREADY(tready),
    .busy(l_busy), .done(l_done), .pix_x(l_x), .pix_y(l_y), .pix_cnt(l_cnt)
  );

  assign m_tdata  = sel_l ? l_tdata  : s_tdata;
  assign m_tvalid = sel_l ? l_tvalid : s_tvalid;
  assign m_busy   = sel_l ? l_busy   : s_busy;
  assign m_done   = sel_l ? l_done   : s_done;
  assign m_x      = sel_l ? l_x      : s_x;
  assign m_y      = sel_l ? l_y      : s_y;
  assign m_cnt    = sel_l ? l_cnt    : s_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    start = 1'b0;
    tready = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  // Reference pixel from the pattern rules; lf is the model LFSR value for this beat.
  function automatic logic [7:0] exp_pix(input int pat, input int sd, input int x, input int y,
                                         input logic [7:0] lf);
    case (pat)
      0:       return 8'((x + y + sd) % 256);
      1:       return lf;
      2:       return 8'(sd);
      default: return 8'((x % 256) ^ (y % 256) ^ sd);
    endcase
  endfunction

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return 8'((int'(s) * 2) % 256) | {7'd0, fb};
  endfunction

  // Runs one frame on the selected instance; mode 0 ready high, 1 random ready, 2 five-cycle stall.
  task automatic run_frame(input string name, input int pat, input int sd, input int gp,
                           input int mode, input bit mid_start);
    int w, h, n, k, gap_left, steps, stall, budget;
    bit rdy, done_seen;
    logic [7:0] lf;
    logic [48:0] act, expv;
    w = sel_l ? 20 : 4;
    h = sel_l ? 15 : 3;
    n = w * h;
    budget = n * (gp + 1) * 8 + 50;
    lf = (sd == 0) ? 8'h01 : 8'(sd);
    pattern_sel = 2'(pat);
    seed = 8'(sd);
    gap = 4'(gp);
    tready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0; gap_left = 0; steps = 0; stall = 0; done_seen = 1'b0;
    while (!done_seen && steps < budget) begin
      if (k == n) begin
        checks++;
        if ({m_done, m_busy, m_tvalid, m_cnt} !== {1'b1, 1'b0, 1'b0, 19'(n)}) begin
          errors++;
          $display("FAIL %s end: done/busy/valid/cnt got %b %b %b %0d want 1 0 0 %0d",
                   name, m_done, m_busy, m_tvalid, m_cnt, n);
        end
        done_seen = 1'b1;
      end else if (gap_left > 0) begin
        checks++;
        if ({m_tvalid, m_busy} !== 2'b01) begin
          errors++;
          $display("FAIL %s gap beat %0d: valid=%b busy=%b want valid=0 busy=1", name, k, m_tvalid, m_busy);
        end
        gap_left--;
      end else begin
        expv = {1'b1, 1'b1, 1'b0, exp_pix(pat, sd, k % w, k / w, lf), 9'(k % w), 10'(k / w), 19'(k)};
        act  = {m_tvalid, m_busy, m_done, m_tdata, m_x, m_y, m_cnt};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL %s pixel %0d: got v=%b d=%h x=%0d y=%0d c=%0d want v=1 d=%h x=%0d y=%0d c=%0d",
                   name, k, m_tvalid, m_tdata, m_x, m_y, m_cnt, expv[45:38], k % w, k / w, k);
        end
      end
      if (!done_seen) begin
        case (mode)
          0: rdy = 1'b1;
          1: rdy = ($urandom_range(0, 99) < 60);
          default: begin
            if (k == 5 && stall < 5 && m_tvalid) begin
              rdy = 1'b0;
              stall++;
            end else begin
              rdy = 1'b1;
            end
          end
        endcase
        tready = rdy;
        if (mid_start) begin
          start = ($urandom_range(0, 9) == 0);
          pattern_sel = 2'($urandom);
          seed = 8'($urandom);
          gap = 4'($urandom);
        end
        if (m_tvalid && rdy && gap_left == 0 && k < n) begin
          captured[k] = m_tdata;
          k++;
          lf = lfsr_adv(lf);
          if (k < n) gap_left = gp;
        end
        step();
        steps++;
      end
    end
    start = 1'b0;
    tready = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: beats %0d want %0d", name, k, n);
    end
    if (mode == 0) begin
      checks++;
      if (steps != (n - 1) * (gp + 1) + 1) begin
        errors++;
        $display("FAIL %s cycles: got %0d want %0d", name, steps, (n - 1) * (gp + 1) + 1);
      end
    end
    step();
    checks++;
    if ({m_done, m_busy, m_tvalid} !== 3'b000) begin
      errors++;
      $display("FAIL %s post-done: done/busy/valid got %b%b%b want 000", name, m_done, m_busy, m_tvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; tready = 1'b0; pattern_sel = 2'd0; seed = 8'd0; gap = 4'd0;
    repeat (2) step();
    checks++;
    if ({s_tvalid, s_tdata, s_busy, s_done, s_x, s_y, s_cnt} !== 49'd0) begin
      errors++;
      $display("FAIL reset small: v=%b d=%h b=%b dn=%b x=%0d y=%0d c=%0d want all 0",
               s_tvalid, s_tdata, s_busy, s_done, s_x, s_y, s_cnt);
    end
    checks++;
    if ({l_tvalid, l_tdata, l_busy, l_done, l_x, l_y, l_cnt} !== 49'd0) begin
      errors++;
      $display("FAIL reset large: v=%b d=%h c=%0d want all 0", l_tvalid, l_tdata, l_cnt);
    end
    rst = 1'b1;
    tready = 1'b1;
    repeat (2) step();
    checks++;
    if ({s_tvalid, s_busy, s_cnt} !== 21'd0) begin
      errors++;
      $display("FAIL idle ready: v=%b b=%b c=%0d want 0 0 0", s_tvalid, s_busy, s_cnt);
    end
    tready = 1'b0;
  endtask

  task automatic test_ramp_small();
    logic [7:0] spec_seq [0:11];
    spec_seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd5};
    sel_l = 1'b0;
    apply_reset();
    run_frame("ramp4x3", 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (captured[i] !== spec_seq[i]) begin
        errors++;
        $display("FAIL ramp table %0d: got %0d want %0d", i, captured[i], spec_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    sel_l = 1'b0;
    apply_reset();
    run_frame("stall", 0, int'($urandom_range(0, 255)), 0, 2, 1'b0);
  endtask

  task automatic test_gap_const();
    sel_l = 1'b0;
    apply_reset();
    run_frame("gap3", 2, 8'hA5, 3, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (captured[i] !== 8'hA5) begin
        errors++;
        $display("FAIL const beat %0d: got %h want a5", i, captured[i]);
      end
    end
  endtask

  task automatic test_lfsr();
    bit seen [0:255];
    int distinct;
    sel_l = 1'b1;
    apply_reset();
    run_frame("lfsr", 1, 0, 0, 1, 1'b0);
    checks++;
    if (captured[0] !== 8'h01) begin
      errors++;
      $display("FAIL lfsr first: got %h want 01", captured[0]);
    end
    checks++;
    if (captured[255] !== captured[0]) begin
      errors++;
      $display("FAIL lfsr period: beat255=%h want %h", captured[255], captured[0]);
    end
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0;
    for (int i = 0; i < 255; i++) begin
      if (!seen[captured[i]]) distinct++;
      seen[captured[i]] = 1'b1;
    end
    checks++;
    if (distinct != 255) begin
      errors++;
      $display("FAIL lfsr distinct: got %0d want 255", distinct);
    end
  endtask

  task automatic test_mid_start();
    sel_l = 1'b1;
    apply_reset();
    run_frame("midstart", 0, int'($urandom_range(0, 255)), 1, 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    sel_l = 1'b1;
    apply_reset();
    pattern_sel = 2'd0; seed = 8'h20; gap = 4'd0; tready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    checks++;
    if ({m_cnt, m_x, m_tvalid} !== {19'd7, 9'd7, 1'b1}) begin
      errors++;
      $display("FAIL pre-reset: cnt=%0d x=%0d v=%b want 7 7 1", m_cnt, m_x, m_tvalid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, m_tdata, m_busy, m_done, m_x, m_y, m_cnt} !== 49'd0) begin
      errors++;
      $display("FAIL async reset: v=%b d=%h b=%b c=%0d want all 0", m_tvalid, m_tdata, m_busy, m_cnt);
    end
    repeat (3) begin
      step();
      checks++;
      if ({m_done, m_tvalid} !== 2'b00) begin
        errors++;
        $display("FAIL in reset: done=%b v=%b want 0 0", m_done, m_tvalid);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if ({m_done, m_busy, m_tvalid} !== 3'b000) begin
      errors++;
      $display("FAIL after release: done/busy/v=%b%b%b want 000", m_done, m_busy, m_tvalid);
    end
    run_frame("restart", 3, int'($urandom_range(0, 255)), 0, 1, 1'b0);
  endtask

  task automatic test_full_frame();
    sel_l = 1'b1;
    apply_reset();
    run_frame("full", 3, int'($urandom_range(0, 255)), 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel_l = 1'b0;
    apply_reset();
    for (int i = 0; i < 6; i++)
      run_frame("b2b", int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 4)), 1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel_l = 1'b0;
    test_reset();
    test_ramp_small();
    test_backpressure();
    test_gap_const();
    test_lfsr();
    test_mid_start();
    test_reset_mid();
    test_full_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
